batt_sched: RTL and testbench
=============================

Name: batt_sched

Overview:
- Controller and arbiter for the battery A2D conversion resource.
- Merges two conversion requesters onto the single A2D strt_cnv/cnv_cmplt handshake: on-demand host requests from cmd_cfg, and periodic autonomous requests from an internal timer.
- Latches each result, then qualifies battery-low and battery-critical flags that feed LEDs and the motor-kill path.
- Sits between cmd_cfg and A2D_intf.

Parameters:
- PERIOD_W, 22: autonomous sample interval is 2^PERIOD_W clk cycles.
- TMO_CYC, 8192: clk cycles allowed between strt_cnv and cnv_cmplt.
- LOW_THRESH, 8'hA0: batt below this counts as a low sample.
- HYST, 8'h08: recovery threshold is LOW_THRESH+HYST.
- CRIT_THRESH, 8'h90: a single sample below this sets batt_crit.
- LOW_CNT, 3: consecutive samples needed to change batt_low.

Ports:
- clk  input  1  system clock, 50MHz
- rst_n  input  1  asynchronous active-low reset, already synchronized by rst_synch
- host_strt  input  1  one-cycle conversion request from cmd_cfg
- host_cmplt  output  1  one-cycle pulse: host-requested result valid on batt
- strt_cnv  output  1  one-cycle start pulse to A2D_intf
- cnv_cmplt  input  1  one-cycle completion pulse from A2D_intf
- res  input  12  A2D result; only res[11:4] is used
- batt  output  8  last valid battery sample
- batt_low  output  1  qualified low-battery flag
- batt_crit  output  1  sticky critical flag
- clr_crit  input  1  clears batt_crit
- tmo_err  output  1  sticky flag: a conversion timed out

Behaviour:
- Reset values:
  - All outputs 0.
  - Timer 0, pending flags 0, sample counters 0, state IDLE.
- Timer:
  - Free-running PERIOD_W-bit counter.
  - Wrap to 0 sets auto_pend.
  - If auto_pend is already set, the wrap is dropped; at most one request is queued.
- host_strt sets host_pend in any state. A repeat while pending coalesces into the one pending request.
- FSM states: IDLE, CONV_HOST, CONV_AUTO.
- IDLE:
  - If host_pend: assert strt_cnv, clear host_pend, go to CONV_HOST.
  - Else if auto_pend: assert strt_cnv, clear auto_pend, go to CONV_AUTO.
  - Host wins simultaneous requests.
  - strt_cnv is registered and occurs the cycle after the decision.
  - Exactly one strt_cnv pulse per conversion.
- CONV_*, on cnv_cmplt:
  - batt <= res[11:4].
  - Run the qualification update.
  - Return to IDLE.
  - From CONV_HOST only, pulse host_cmplt in the same cycle batt updates, i.e. 1 cycle after cnv_cmplt.
- CONV_*, timeout:
  - Wait counter reaches TMO_CYC-1 with no cnv_cmplt: set tmo_err, return to IDLE.
  - batt is unchanged.
  - From CONV_HOST, host_cmplt still pulses so cmd_cfg never hangs.
  - cnv_cmplt and timeout in the same cycle: completion wins.
- cnv_cmplt received in IDLE is ignored.
- A new request arriving while converting is served on the next return to IDLE.
- Qualification, per valid sample, with s = res[11:4]:
  - Low-going: if s < LOW_THRESH, increment low_cnt (saturating) and clear ok_cnt. When low_cnt reaches LOW_CNT, batt_low <= 1.
  - Recovery: if s >= LOW_THRESH+HYST, increment ok_cnt and clear low_cnt. When ok_cnt reaches LOW_CNT, batt_low <= 0.
  - In the hysteresis band, both counters clear and batt_low holds.
  - LOW_THRESH+HYST is computed 9-bit and saturates at 8'hFF.
  - s < CRIT_THRESH sets batt_crit the same cycle as the batt update.
- batt_crit:
  - Cleared only by clr_crit or reset.
  - If clr_crit and a crit sample coincide, set wins.
- tmo_err: cleared only by reset.
- Reset mid-conversion: immediate return to reset values; no strt_cnv pulse after reset release until a new request arrives.

Decomposition:
- Package batt_pkg: FSM state enum (IDLE, CONV_HOST, CONV_AUTO) and default threshold constants.
- Sub-module batt_qual: low/ok counters, hysteresis compare and crit flag. Inputs: sample strobe, 8-bit sample, clr_crit.
- batt_sched keeps the timer, pending flags, FSM and timeout.

Test Plan:
- Bench uses PERIOD_W=8 and TMO_CYC=64.
- Autonomous: no host activity -> strt_cnv pulses every 256 cycles. A2D model returns res=12'hC30 after 40 cycles -> batt=8'hC3, host_cmplt stays 0.
- Arbitration: host_strt in the same cycle as timer wrap -> first conversion is CONV_HOST and host_cmplt pulses once. The second strt_cnv follows immediately after return to IDLE (autonomous).
- Hysteresis: samples 8'h9F, 8'h9F, 8'h9F -> batt_low=1 after the third. Then 8'hA4 ×3 -> batt_low stays 1 (band). Then 8'hA8 ×3 -> batt_low=0 after the third.
- Critical: one sample 8'h8F -> batt_crit=1. Pulse clr_crit -> batt_crit=0. clr_crit coincident with sample 8'h80 -> batt_crit stays 1.
- Timeout: host_strt with the A2D model silent -> after 64 cycles tmo_err=1, host_cmplt pulses, batt unchanged, FSM returns to IDLE. The next autonomous conversion completes normally.
- Reset: assert rst_n low mid-CONV_AUTO -> all outputs 0 immediately. Stale cnv_cmplt after release is ignored; batt stays 0.

Source files
------------

// File: rtl/batt_pkg.sv
// Shared types and default tuning for the battery conversion scheduler.
// Latency: n/a (types, constants and a constant-foldable helper only).
// Backpressure: n/a.
package batt_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CONV_HOST = 2'd1,
      CONV_AUTO = 2'd2
   } state_t;

   localparam int unsigned DEF_PERIOD_W    = 22;
   localparam int unsigned DEF_TMO_CYC     = 8192;
   localparam logic [7:0]  DEF_LOW_THRESH  = 8'hA0;
   localparam logic [7:0]  DEF_HYST        = 8'h08;
   localparam logic [7:0]  DEF_CRIT_THRESH = 8'h90;
   localparam int unsigned DEF_LOW_CNT     = 3;

   // 8-bit add that clamps to 8'hFF instead of wrapping, so a high threshold
   // plus hysteresis can never fold back into a small recovery level.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/batt_sched_if.sv
// A2D conversion handshake between the scheduler and the converter front end.
// Latency: n/a (wires only).
// Backpressure: none; start and completion are single-cycle pulses.
// Ports: strt_cnv (scheduler -> A2D), cnv_cmplt and 12-bit res (A2D -> scheduler).
interface batt_sched_if;
   logic        strt_cnv;
   logic        cnv_cmplt;
   logic [11:0] res;

   modport master (output strt_cnv, input cnv_cmplt, input res);
   modport slave  (input strt_cnv, output cnv_cmplt, output res);
endinterface

// File: rtl/batt_qual.sv
// Qualifies battery samples into a debounced low flag and a sticky critical flag.
// Latency: flags update on the clock edge that captures the sample strobe.
// Backpressure: none; accepts one sample per cycle whenever smp_vld is high.
// Ports: clk, rst_n; smp_vld/smp (8-bit sample), clr_crit; outputs batt_low, batt_crit.
module batt_qual
   import batt_pkg::*;
#(
   parameter logic [7:0]  LOW_THRESH  = DEF_LOW_THRESH,
   parameter logic [7:0]  HYST        = DEF_HYST,
   parameter logic [7:0]  CRIT_THRESH = DEF_CRIT_THRESH,
   parameter int unsigned LOW_CNT     = DEF_LOW_CNT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       smp_vld,
   input  logic [7:0] smp,
   input  logic       clr_crit,
   output logic       batt_low,
   output logic       batt_crit
);

   localparam int unsigned      CNT_W     = $clog2(LOW_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(LOW_CNT);
   localparam logic [7:0]       OK_THRESH = sat_add8(LOW_THRESH, HYST);

   logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
   logic [CNT_W-1:0] ok_cnt_q,  ok_cnt_d;
   logic             batt_low_q, batt_low_d;
   logic             batt_crit_q, batt_crit_d;

   always_comb begin
      low_cnt_d   = low_cnt_q;
      ok_cnt_d    = ok_cnt_q;
      batt_low_d  = batt_low_q;
      batt_crit_d = batt_crit_q;

      if (clr_crit) begin
         batt_crit_d = 1'b0;
      end

      if (smp_vld) begin
         // Evaluated after the clear so a coincident critical sample wins.
         if (smp < CRIT_THRESH) begin
            batt_crit_d = 1'b1;
         end

         if (smp < LOW_THRESH) begin
            ok_cnt_d = '0;
            if (low_cnt_q != CNT_MAX) begin
               low_cnt_d = low_cnt_q + CNT_W'(1);
            end
            if (low_cnt_d == CNT_MAX) begin
               batt_low_d = 1'b1;
            end
         end else if (smp >= OK_THRESH) begin
            low_cnt_d = '0;
            if (ok_cnt_q != CNT_MAX) begin
               ok_cnt_d = ok_cnt_q + CNT_W'(1);
            end
            if (ok_cnt_d == CNT_MAX) begin
               batt_low_d = 1'b0;
            end
         end else begin
            // Hysteresis band: a run must be unbroken to flip the flag.
            low_cnt_d = '0;
            ok_cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         low_cnt_q   <= '0;
         ok_cnt_q    <= '0;
         batt_low_q  <= 1'b0;
         batt_crit_q <= 1'b0;
      end else begin
         low_cnt_q   <= low_cnt_d;
         ok_cnt_q    <= ok_cnt_d;
         batt_low_q  <= batt_low_d;
         batt_crit_q <= batt_crit_d;
      end
   end

   assign batt_low  = batt_low_q;
   assign batt_crit = batt_crit_q;

endmodule

// File: rtl/batt_sched.sv
// Arbitrates host and periodic battery conversions onto one A2D and latches results.
// Latency: strt_cnv 1 cycle after dispatch; batt/host_cmplt 1 cycle after cnv_cmplt.
// Backpressure: one request of each kind is queued; extra requests coalesce.
// Ports: clk, rst_n; host_strt/host_cmplt to cmd_cfg; a2d (master modport:
//        strt_cnv, cnv_cmplt, res); batt, batt_low, batt_crit, clr_crit, tmo_err.
module batt_sched
   import batt_pkg::*;
#(
   parameter int unsigned PERIOD_W    = DEF_PERIOD_W,
   parameter int unsigned TMO_CYC     = DEF_TMO_CYC,
   parameter logic [7:0]  LOW_THRESH  = DEF_LOW_THRESH,
   parameter logic [7:0]  HYST        = DEF_HYST,
   parameter logic [7:0]  CRIT_THRESH = DEF_CRIT_THRESH,
   parameter int unsigned LOW_CNT     = DEF_LOW_CNT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              host_strt,
   output logic              host_cmplt,
   batt_sched_if.master      a2d,
   output logic [7:0]        batt,
   output logic              batt_low,
   output logic              batt_crit,
   input  logic              clr_crit,
   output logic              tmo_err
);

   localparam int unsigned      TMO_W    = ($clog2(TMO_CYC) < 1) ? 1 : $clog2(TMO_CYC);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

   state_t              state_q, state_d;
   logic [PERIOD_W-1:0] timer_q, timer_d;
   logic                auto_pend_q, auto_pend_d;
   logic                host_pend_q, host_pend_d;
   logic [TMO_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                strt_cnv_q, strt_cnv_d;
   logic                host_cmplt_q, host_cmplt_d;
   logic [7:0]          batt_q, batt_d;
   logic                tmo_err_q, tmo_err_d;
   logic                smp_vld;

   // The converter returns 12 bits; only the top byte is meaningful here.
   logic unused_res_lsb;
   assign unused_res_lsb = ^a2d.res[3:0];

   always_comb begin
      timer_d      = timer_q + PERIOD_W'(1);
      auto_pend_d  = auto_pend_q;
      host_pend_d  = host_pend_q;
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      strt_cnv_d   = 1'b0;
      host_cmplt_d = 1'b0;
      batt_d       = batt_q;
      tmo_err_d    = tmo_err_q;
      smp_vld      = 1'b0;

      case (state_q)
         IDLE: begin
            wait_cnt_d = '0;
            if (host_pend_q) begin
               strt_cnv_d  = 1'b1;
               host_pend_d = 1'b0;
               state_d     = CONV_HOST;
            end else if (auto_pend_q) begin
               strt_cnv_d  = 1'b1;
               auto_pend_d = 1'b0;
               state_d     = CONV_AUTO;
            end
         end
         CONV_HOST, CONV_AUTO: begin
            wait_cnt_d = wait_cnt_q + TMO_W'(1);
            // Completion takes priority over a timeout landing in the same cycle.
            if (a2d.cnv_cmplt) begin
               batt_d       = a2d.res[11:4];
               smp_vld      = 1'b1;
               host_cmplt_d = (state_q == CONV_HOST);
               state_d      = IDLE;
            end else if (wait_cnt_q == TMO_LAST) begin
               tmo_err_d    = 1'b1;
               host_cmplt_d = (state_q == CONV_HOST);
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Set after the dispatch clear so a request arriving in the dispatch
      // cycle is held for the next idle slot rather than lost.
      if (host_strt) begin
         host_pend_d = 1'b1;
      end
      if (timer_q == '1) begin
         auto_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         timer_q      <= '0;
         auto_pend_q  <= 1'b0;
         host_pend_q  <= 1'b0;
         wait_cnt_q   <= '0;
         strt_cnv_q   <= 1'b0;
         host_cmplt_q <= 1'b0;
         batt_q       <= 8'h00;
         tmo_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         auto_pend_q  <= auto_pend_d;
         host_pend_q  <= host_pend_d;
         wait_cnt_q   <= wait_cnt_d;
         strt_cnv_q   <= strt_cnv_d;
         host_cmplt_q <= host_cmplt_d;
         batt_q       <= batt_d;
         tmo_err_q    <= tmo_err_d;
      end
   end

   batt_qual #(
      .LOW_THRESH  (LOW_THRESH),
      .HYST        (HYST),
      .CRIT_THRESH (CRIT_THRESH),
      .LOW_CNT     (LOW_CNT)
   ) u_qual (
      .clk       (clk),
      .rst_n     (rst_n),
      .smp_vld   (smp_vld),
      .smp       (a2d.res[11:4]),
      .clr_crit  (clr_crit),
      .batt_low  (batt_low),
      .batt_crit (batt_crit)
   );

   assign a2d.strt_cnv = strt_cnv_q;
   assign host_cmplt   = host_cmplt_q;
   assign batt         = batt_q;
   assign tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_batt_sched.sv
// Directed bench for batt_sched with a behavioural A2D responder.
// Latency: n/a.
// Backpressure: n/a.
module tb_batt_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       host_strt = 1'b0;
   logic       clr_crit = 1'b0;
   logic       host_cmplt;
   logic [7:0] batt;
   logic       batt_low;
   logic       batt_crit;
   logic       tmo_err;

   int          checks = 0;
   int          errors = 0;
   int          a2d_dly = 40;
   logic [11:0] a2d_res = 12'h000;
   bit          a2d_silent = 1'b0;

   batt_sched_if a2d ();

   batt_sched #(
      .PERIOD_W (8),
      .TMO_CYC  (64)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .host_strt  (host_strt),
      .host_cmplt (host_cmplt),
      .a2d        (a2d),
      .batt       (batt),
      .batt_low   (batt_low),
      .batt_crit  (batt_crit),
      .clr_crit   (clr_crit),
      .tmo_err    (tmo_err)
   );

   always #10 clk = ~clk;

   // A2D responder: a start seen on a falling edge is answered a2d_dly falling
   // edges later with a one-cycle completion carrying a2d_res.
   initial begin
      a2d.cnv_cmplt = 1'b0;
      a2d.res       = 12'h000;
      forever begin
         @(negedge clk);
         if (a2d.strt_cnv && !a2d_silent) begin
            repeat (a2d_dly) @(negedge clk);
            a2d.cnv_cmplt = 1'b1;
            a2d.res       = a2d_res;
            @(negedge clk);
            a2d.cnv_cmplt = 1'b0;
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      host_strt = 1'b0;
      clr_crit  = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Issues one host request and waits (bounded) for host_cmplt.
   task automatic do_host_conv(input logic [7:0] s, input bit hold_clr, output bit ok);
      a2d_res   = {s, 4'h5};
      host_strt = 1'b1;
      if (hold_clr) clr_crit = 1'b1;
      @(negedge clk);
      host_strt = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (host_cmplt) ok = 1'b1;
      end
      clr_crit = 1'b0;
   endtask

   task automatic test_reset();
      bit quiet;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (batt !== 8'h00) begin errors++; $display("FAIL rst_batt: got %h want 00", batt); end
      checks++; if (batt_low !== 1'b0) begin errors++; $display("FAIL rst_batt_low: got %b want 0", batt_low); end
      checks++; if (batt_crit !== 1'b0) begin errors++; $display("FAIL rst_batt_crit: got %b want 0", batt_crit); end
      checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL rst_tmo_err: got %b want 0", tmo_err); end
      checks++; if (host_cmplt !== 1'b0) begin errors++; $display("FAIL rst_host_cmplt: got %b want 0", host_cmplt); end
      checks++; if (a2d.strt_cnv !== 1'b0) begin errors++; $display("FAIL rst_strt_cnv: got %b want 0", a2d.strt_cnv); end
      rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (a2d.strt_cnv !== 1'b0 || host_cmplt !== 1'b0) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL rst_quiet: got activity=%b want none before timer wrap", !quiet); end
   endtask

   task automatic test_autonomous();
      int cyc;
      int cyc2;
      bit got;
      bit seen_hc;
      a2d_silent = 1'b0;
      a2d_dly    = 40;
      a2d_res    = 12'hC30;
      do_reset();
      cyc = 0; got = 1'b0;
      while (!got && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (a2d.strt_cnv) got = 1'b1;
      end
      checks++; if (cyc !== 257) begin errors++; $display("FAIL auto_first_strt: got cycle %0d want 257", cyc); end
      seen_hc = 1'b0; got = 1'b0; cyc2 = 0;
      for (int i = 1; i <= 256; i++) begin
         @(negedge clk);
         if (host_cmplt) seen_hc = 1'b1;
         if (i == 40) begin
            checks++; if (batt !== 8'h00) begin errors++; $display("FAIL auto_batt_early: got %h want 00", batt); end
         end
         if (i == 41) begin
            checks++; if (batt !== 8'hC3) begin errors++; $display("FAIL auto_batt: got %h want C3", batt); end
         end
         if (a2d.strt_cnv && !got) begin got = 1'b1; cyc2 = i; end
      end
      checks++; if (cyc2 !== 256) begin errors++; $display("FAIL auto_period: got %0d want 256", cyc2); end
      checks++; if (seen_hc !== 1'b0) begin errors++; $display("FAIL auto_host_cmplt: got pulse=%b want 0", seen_hc); end
      checks++; if (batt_low !== 1'b0) begin errors++; $display("FAIL auto_batt_low: got %b want 0", batt_low); end
   endtask

   task automatic test_arbitration();
      int s1, s2, hc_n, hc_at;
      logic [7:0] hc_batt;
      a2d_dly = 40;
      a2d_res = 12'hB40;
      do_reset();
      s1 = 0; s2 = 0; hc_n = 0; hc_at = 0; hc_batt = 8'h00;
      for (int i = 1; i <= 345; i++) begin
         @(negedge clk);
         if (a2d.strt_cnv) begin
            if (s1 == 0) s1 = i;
            else if (s2 == 0) s2 = i;
         end
         if (host_cmplt) begin hc_n++; hc_at = i; hc_batt = batt; end
         host_strt = (i == 255);
      end
      host_strt = 1'b0;
      checks++; if (s1 !== 257) begin errors++; $display("FAIL arb_first_strt: got %0d want 257", s1); end
      checks++; if (hc_n !== 1) begin errors++; $display("FAIL arb_host_cmplt_count: got %0d want 1", hc_n); end
      checks++; if (hc_at !== 298) begin errors++; $display("FAIL arb_host_cmplt_cycle: got %0d want 298", hc_at); end
      checks++; if (hc_batt !== 8'hB4) begin errors++; $display("FAIL arb_host_batt: got %h want B4", hc_batt); end
      checks++; if (s2 !== 299) begin errors++; $display("FAIL arb_second_strt: got %0d want 299", s2); end
   endtask

   task automatic test_hysteresis();
      logic [7:0] vals [9];
      logic       exp_low [9];
      bit ok;
      vals    = '{8'h9F, 8'h9F, 8'h9F, 8'hA4, 8'hA4, 8'hA4, 8'hA8, 8'hA8, 8'hA8};
      exp_low = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      a2d_dly = 4;
      do_reset();
      for (int k = 0; k < 9; k++) begin
         do_host_conv(vals[k], 1'b0, ok);
         checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hyst_done[%0d]: got timeout want host_cmplt", k); end
         checks++; if (batt !== vals[k]) begin errors++; $display("FAIL hyst_batt[%0d]: got %h want %h", k, batt, vals[k]); end
         checks++; if (batt_low !== exp_low[k]) begin errors++; $display("FAIL hyst_low[%0d]: got %b want %b", k, batt_low, exp_low[k]); end
      end
      checks++; if (batt_crit !== 1'b0) begin errors++; $display("FAIL hyst_crit: got %b want 0", batt_crit); end
   endtask

   task automatic test_critical();
      bit ok;
      a2d_dly = 4;
      do_reset();
      do_host_conv(8'h8F, 1'b0, ok);
      checks++; if (batt_crit !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL crit_set: got crit=%b done=%b want 1 1", batt_crit, ok); end
      do_host_conv(8'hC0, 1'b0, ok);
      checks++; if (batt_crit !== 1'b1) begin errors++; $display("FAIL crit_sticky: got %b want 1", batt_crit); end
      clr_crit = 1'b1;
      @(negedge clk);
      clr_crit = 1'b0;
      checks++; if (batt_crit !== 1'b0) begin errors++; $display("FAIL crit_clear: got %b want 0", batt_crit); end
      do_host_conv(8'h90, 1'b0, ok);
      checks++; if (batt_crit !== 1'b0) begin errors++; $display("FAIL crit_boundary_90: got %b want 0", batt_crit); end
      do_host_conv(8'h80, 1'b1, ok);
      checks++; if (batt_crit !== 1'b1 || ok !== 1'b1) begin errors++; $display("FAIL crit_set_wins: got crit=%b done=%b want 1 1", batt_crit, ok); end
      @(negedge clk);
      checks++; if (batt_crit !== 1'b1) begin errors++; $display("FAIL crit_after_clr: got %b want 1", batt_crit); end
   endtask

   task automatic test_timeout();
      bit ok;
      bit got;
      bit seen_hc;
      a2d_dly    = 4;
      a2d_silent = 1'b0;
      do_reset();
      do_host_conv(8'hC3, 1'b0, ok);
      checks++; if (batt !== 8'hC3 || ok !== 1'b1) begin errors++; $display("FAIL tmo_pre_batt: got %h done=%b want C3 1", batt, ok); end
      a2d_silent = 1'b1;
      host_strt  = 1'b1;
      @(negedge clk);
      host_strt = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (a2d.strt_cnv) got = 1'b1;
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_strt: got none want strt_cnv"); end
      for (int i = 1; i <= 65; i++) begin
         @(negedge clk);
         if (i == 63) begin
            checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", tmo_err); end
         end
         if (i == 64) begin
            checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", tmo_err); end
            checks++; if (host_cmplt !== 1'b1) begin errors++; $display("FAIL tmo_host_cmplt: got %b want 1", host_cmplt); end
            checks++; if (batt !== 8'hC3) begin errors++; $display("FAIL tmo_batt_held: got %h want C3", batt); end
         end
         if (i == 65) begin
            checks++; if (host_cmplt !== 1'b0) begin errors++; $display("FAIL tmo_host_cmplt_once: got %b want 0", host_cmplt); end
         end
      end
      a2d_silent = 1'b0;
      a2d_dly    = 40;
      a2d_res    = 12'hB70;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (a2d.strt_cnv) got = 1'b1;
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL tmo_next_auto_strt: got none want strt_cnv"); end
      seen_hc = 1'b0;
      repeat (41) begin
         @(negedge clk);
         if (host_cmplt) seen_hc = 1'b1;
      end
      checks++; if (batt !== 8'hB7) begin errors++; $display("FAIL tmo_next_auto_batt: got %h want B7", batt); end
      checks++; if (tmo_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", tmo_err); end
      checks++; if (seen_hc !== 1'b0) begin errors++; $display("FAIL tmo_auto_host_cmplt: got %b want 0", seen_hc); end
   endtask

   task automatic test_reset_midconv();
      bit ok;
      bit got;
      bit seen_strt;
      bit batt_moved;
      a2d_dly    = 4;
      a2d_silent = 1'b0;
      do_reset();
      do_host_conv(8'h8F, 1'b0, ok);
      a2d_silent = 1'b1;
      host_strt  = 1'b1;
      @(negedge clk);
      host_strt = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (tmo_err) got = 1'b1;
      end
      a2d_silent = 1'b0;
      a2d_dly    = 40;
      a2d_res    = 12'hC30;
      got = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (a2d.strt_cnv) got = 1'b1;
      end
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL rstmid_auto_strt: got none want strt_cnv"); end
      repeat (10) @(negedge clk);
      checks++; if (batt !== 8'h8F || batt_crit !== 1'b1 || tmo_err !== 1'b1) begin
         errors++; $display("FAIL rstmid_pre: got batt=%h crit=%b tmo=%b want 8F 1 1", batt, batt_crit, tmo_err);
      end
      rst_n = 1'b0;
      #1;
      checks++; if (batt !== 8'h00) begin errors++; $display("FAIL rstmid_batt: got %h want 00", batt); end
      checks++; if (batt_crit !== 1'b0) begin errors++; $display("FAIL rstmid_crit: got %b want 0", batt_crit); end
      checks++; if (tmo_err !== 1'b0) begin errors++; $display("FAIL rstmid_tmo: got %b want 0", tmo_err); end
      checks++; if (a2d.strt_cnv !== 1'b0 || host_cmplt !== 1'b0 || batt_low !== 1'b0) begin
         errors++; $display("FAIL rstmid_pulses: got strt=%b hc=%b low=%b want 0 0 0", a2d.strt_cnv, host_cmplt, batt_low);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen_strt = 1'b0; batt_moved = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (a2d.strt_cnv) seen_strt = 1'b1;
         if (batt !== 8'h00) batt_moved = 1'b1;
      end
      checks++; if (seen_strt !== 1'b0) begin errors++; $display("FAIL rstmid_no_strt: got strt=%b want 0", seen_strt); end
      checks++; if (batt_moved !== 1'b0) begin errors++; $display("FAIL rstmid_stale_ignored: got batt=%h want 00", batt); end
   endtask

   initial begin
      test_reset();
      test_autonomous();
      test_arbitration();
      test_hysteresis();
      test_critical();
      test_timeout();
      test_reset_midconv();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
